simon_game_core: RTL
====================

// Module: simon_game_core
// PURPOSE
//   Parametrised memory-game ("Simon") controller: shows a growing pseudo-random key sequence on
//   NUM_KEYS LEDs, then checks player key presses against it round by round. Adds a win state,
//   per-press timeout, multi-key error detection and a replayable LFSR sequence (no stored array).
//   Sits between the key synchronizers and the seven-segment round/high-score displays.
// PARAMETERS
//   NUM_KEYS      4     number of keys/LEDs; power of two, 2..8; KW = clog2(NUM_KEYS)
//   MAX_ROUNDS    99    rounds to win; 1..(2**SCORE_W)-1
//   SCORE_W       8     width of round / high_score
//   SHOW_TICKS    32    ticks each sequence LED stays lit
//   GAP_TICKS     8     dark ticks between shown LEDs
//   TIMEOUT_TICKS 4095  ticks allowed per expected press in PLAY
// PORTS
//   clk         in   1         system clock; every register on posedge
//   rst         in   1         synchronous, active-high reset
//   tick        in   1         one-cycle timing strobe; all *_TICKS counters advance only on tick
//   keys        in   NUM_KEYS  synchronized key levels, active-high
//   key_leds    out  NUM_KEYS  one-hot during SHOW_ON; mirrors keys in PLAY; else 0
//   play_led    out  1         1 only in PLAY
//   round       out  SCORE_W   current round (sequence length); 0 in IDLE
//   high_score  out  SCORE_W   best completed round count; survives games, cleared only by rst
//   game_over   out  1         1 in LOST
//   win         out  1         1 in WIN
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; LFSR=16'hACE1; free counter=0; tick counters=0.
//   Press detect: keys_q registered each clk; press = (keys!=0) && (keys_q==0). A press is
//     valid iff keys is one-hot; index = position of the set bit. Held keys never re-trigger.
//   Sequence: 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1; element = LFSR[KW-1:0], then step.
//     seed latched at game start = free counter | 16'h1 (never zero). Replay = reload seed.
//   States:
//   IDLE: outputs low except high_score. On press (valid or not): seed<=ctr|1, round<=1,
//     ->SHOW_ON with LFSR reloaded and idx=0.
//   SHOW_ON: key_leds=onehot(element). After SHOW_TICKS ticks ->SHOW_GAP.
//   SHOW_GAP: key_leds=0. After GAP_TICKS ticks: idx+1; LFSR steps; if idx+1==round ->PLAY
//     (reload seed, idx=0, timeout=0), else ->SHOW_ON.
//   PLAY: play_led=1. Timeout counter clears on every press, counts ticks otherwise;
//     reaching TIMEOUT_TICKS ->LOST. Press invalid (multi-key) or index!=element ->LOST.
//     Correct press: if idx+1<round, idx+1, LFSR steps. If idx+1==round: if round==MAX_ROUNDS
//     ->WIN, else round+1, reload seed, ->SHOW_ON with idx=0.
//   LOST / WIN: score = round-1 (LOST) or round (WIN); high_score<=max(high_score,score) on entry
//     cycle. Stay until press, then behave as IDLE start (same cycle ->SHOW_ON, round=1).
//   Ticks and presses in the same cycle: press is evaluated first; timeout cleared, no LOST.
//   Tick counters reset to 0 on every state entry; a tick on the entry cycle is not counted.
//   rst mid-game: returns to IDLE next edge, high_score cleared, no stale key_leds.
//   round never exceeds MAX_ROUNDS; no arithmetic wrap anywhere.
// TESTING
//   1 rst high 2 clk, then idle -> all outputs 0, state IDLE, key_leds=0.
//   2 NUM_KEYS=4, press key1 -> round=1; one LED lit exactly SHOW_TICKS ticks, then 0 for
//     GAP_TICKS, then play_led=1; pressing that LED's key -> round=2, replay shows same first LED.
//   3 In round 3 enter 2 correct presses, then a wrong key -> game_over=1, high_score=2.
//   4 In PLAY hold keys=4'b0011 -> game_over=1; separate run with no press for TIMEOUT_TICKS
//     ticks -> game_over=1; a press on tick TIMEOUT_TICKS-1 -> still PLAY.
//   5 MAX_ROUNDS=3, model-driven correct play -> win=1 after round 3, high_score=3; press ->
//     round=1, high_score held at 3.
//   6 Assert rst during SHOW_ON of round 4 -> next cycle IDLE, key_leds=0, high_score=0.

Source files
------------

// File: rtl/simon_game_core.sv
// Simon memory-game controller: replays an LFSR-generated key sequence on LEDs, then
// checks the player's presses round by round, with timeout, multi-key loss and a win state.
module simon_game_core #(
  parameter int NUM_KEYS      = 4,
  parameter int MAX_ROUNDS    = 99,
  parameter int SCORE_W       = 8,
  parameter int SHOW_TICKS    = 32,
  parameter int GAP_TICKS     = 8,
  parameter int TIMEOUT_TICKS = 4095
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] key_leds,
  output logic                play_led,
  output logic [SCORE_W-1:0]  round,
  output logic [SCORE_W-1:0]  high_score,
  output logic                game_over,
  output logic                win
);

  localparam int KW    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int TMAX1 = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TMAX  = (TMAX1 > TIMEOUT_TICKS) ? TMAX1 : TIMEOUT_TICKS;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, SHOW_ON, SHOW_GAP, PLAY, LOST, WIN} state_t;

  state_t              state, state_nx;
  logic [15:0]         lfsr, lfsr_nx, seed, seed_nx, ctr;
  logic [SCORE_W-1:0]  round_q, round_nx, idx, idx_nx, hs_nx;
  logic [TW-1:0]       tcnt, tcnt_nx;
  logic [NUM_KEYS-1:0] keys_q;
  logic                press, valid;
  logic [KW-1:0]       kidx, elem;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  function automatic logic [SCORE_W-1:0] best(input logic [SCORE_W-1:0] a,
                                              input logic [SCORE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [NUM_KEYS-1:0] onehot(input logic [KW-1:0] i);
    return NUM_KEYS'(1) << i;
  endfunction

  assign press = (keys != '0) && (keys_q == '0);
  assign valid = (keys != '0) && ((keys & (keys - NUM_KEYS'(1))) == '0);
  assign elem  = lfsr[KW-1:0];

  always_comb begin
    kidx = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (keys[i]) kidx = KW'(i);
  end

  always_comb begin
    state_nx = state;
    lfsr_nx  = lfsr;
    seed_nx  = seed;
    round_nx = round_q;
    idx_nx   = idx;
    tcnt_nx  = tcnt;
    hs_nx    = high_score;
    case (state)
      IDLE, LOST, WIN: begin
        if (press) begin
          seed_nx  = ctr | 16'h1;
          lfsr_nx  = ctr | 16'h1;
          round_nx = SCORE_W'(1);
          idx_nx   = '0;
          state_nx = SHOW_ON;
        end
      end
      SHOW_ON: begin
        if (tick) begin
          if (tcnt == TW'(SHOW_TICKS - 1)) state_nx = SHOW_GAP;
          else                             tcnt_nx  = tcnt + TW'(1);
        end
      end
      SHOW_GAP: begin
        if (tick) begin
          if (tcnt == TW'(GAP_TICKS - 1)) begin
            if (idx + SCORE_W'(1) == round_q) begin
              lfsr_nx  = seed;
              idx_nx   = '0;
              state_nx = PLAY;
            end else begin
              lfsr_nx  = lfsr_step(lfsr);
              idx_nx   = idx + SCORE_W'(1);
              state_nx = SHOW_ON;
            end
          end else begin
            tcnt_nx = tcnt + TW'(1);
          end
        end
      end
      PLAY: begin
        // a press outranks a simultaneous tick, so it can never time out
        if (press) begin
          tcnt_nx = '0;
          if (!valid || kidx != elem) begin
            state_nx = LOST;
          end else if (idx + SCORE_W'(1) < round_q) begin
            idx_nx  = idx + SCORE_W'(1);
            lfsr_nx = lfsr_step(lfsr);
          end else if (round_q == SCORE_W'(MAX_ROUNDS)) begin
            state_nx = WIN;
          end else begin
            round_nx = round_q + SCORE_W'(1);
            lfsr_nx  = seed;
            idx_nx   = '0;
            state_nx = SHOW_ON;
          end
        end else if (tick) begin
          if (tcnt == TW'(TIMEOUT_TICKS - 1)) state_nx = LOST;
          else                                tcnt_nx  = tcnt + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx != state) tcnt_nx = '0;
    if (state_nx == LOST && state != LOST) hs_nx = best(high_score, round_q - SCORE_W'(1));
    if (state_nx == WIN && state != WIN)   hs_nx = best(high_score, round_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= 16'hACE1;
      seed       <= 16'h0;
      ctr        <= 16'h0;
      round_q    <= '0;
      idx        <= '0;
      tcnt       <= '0;
      high_score <= '0;
      keys_q     <= '0;
    end else begin
      state      <= state_nx;
      lfsr       <= lfsr_nx;
      seed       <= seed_nx;
      ctr        <= ctr + 16'h1;
      round_q    <= round_nx;
      idx        <= idx_nx;
      tcnt       <= tcnt_nx;
      high_score <= hs_nx;
      keys_q     <= keys;
    end
  end

  always_comb begin
    key_leds = '0;
    if (state == SHOW_ON)   key_leds = onehot(elem);
    else if (state == PLAY) key_leds = keys;
  end

  assign play_led  = (state == PLAY);
  assign round     = round_q;
  assign game_over = (state == LOST);
  assign win       = (state == WIN);

endmodule
